paddle_emu: RTL and testbench
=============================

PADDLE_EMU -- requirements
Module: paddle_emu

Interface
REQ-001 Parameter W, default 8, paddle output width in bits; legal range 8..12.
REQ-002 Parameter MAX_STEP, default 10, maximum per-packet mouse step magnitude after scaling.
REQ-003 Parameter SHIFT, default 1, arithmetic right shift applied to raw mouse deltas.
REQ-004 Parameter DEADZONE, default 0, analog magnitude at or below which an axis counts as idle.
REQ-005 clk_sys  in  1  system clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 ps2_mouse  in  25  bit 24 packet toggle strobe; [23:16] Y delta magnitude; [15:8] X delta magnitude; bit 5 Y sign; bit 4 X sign; [2:0] buttons.
REQ-008 joya  in  16  analog stick; [7:0] X, signed; [15:8] Y, signed.
REQ-009 mode  in  2  0 auto, 1 analog only, 2 mouse only, 3 treated as auto.
REQ-010 recentre  in  1  single-cycle request to zero both mouse accumulators.
REQ-011 paddle_x, paddle_y  out  W each  signed paddle positions, registered.
REQ-012 btn  out  3  mouse buttons while source is mouse, else 0.
REQ-013 src_mouse  out  1  1 when the current source is mouse.
REQ-014 upd  out  1  one-cycle pulse, coincident with any change of paddle_x or paddle_y.

Function
REQ-015 Source FSM SHALL have two states, SRC_ANALOG (reset state) and SRC_MOUSE.
REQ-016 A mouse event SHALL be detected when ps2_mouse[24] differs from its value registered on the previous cycle.
REQ-017 An analog event SHALL occur when |joya X| > DEADZONE or |joya Y| > DEADZONE; -128 has magnitude 128.
REQ-018 In auto mode:
- analog event -> SRC_ANALOG, both accumulators cleared;
- otherwise a mouse event -> SRC_MOUSE;
- both in the same cycle -> analog wins.
REQ-019 Mode 1 SHALL hold SRC_ANALOG and ignore mouse events; mode 2 SHALL hold SRC_MOUSE and ignore analog events; a mode change SHALL take effect on the next edge.
REQ-020 Delta per axis SHALL be the 9-bit signed value {sign, magnitude byte}, arithmetically shifted right by SHIFT, then clamped to [-MAX_STEP, +MAX_STEP].
REQ-021 On a mouse event in SRC_MOUSE (including the entering event), each accumulator SHALL add its clamped delta and saturate to [-2^(W-1), 2^(W-1)-1]; internal width at least W+1, no wrap-around.
REQ-022 Accumulators, outputs and upd SHALL update on the edge at which the event is detected; latency is 1 cycle from input presentation to output.
REQ-023 In SRC_ANALOG, paddle_x/y SHALL equal joya X/Y sign-extended and shifted left by W-8, registered with 1-cycle latency, including values inside the deadzone.
REQ-024 In SRC_MOUSE, paddle_x/y SHALL equal the accumulators.
REQ-025 recentre SHALL zero both accumulators on that edge. If a mouse event coincides, the result SHALL be the clamped delta applied to 0.
REQ-026 btn SHALL be registered from ps2_mouse[2:0] on each mouse event while in SRC_MOUSE, and SHALL be forced to 0 in SRC_ANALOG.

Reset
REQ-027 On reset: paddle_x = paddle_y = 0, accumulators = 0, btn = 0, src_mouse = 0, upd = 0, state SRC_ANALOG.
REQ-028 On reset, the strobe history register SHALL load the current ps2_mouse[24], so no event is detected on the first cycle after reset.
REQ-029 Reset asserted mid-accumulation SHALL discard all accumulated motion.

Structure
REQ-030 Package paddle_emu_pkg SHALL hold the source state enum, the mode encodings (MODE_AUTO, MODE_ANALOG, MODE_MOUSE) and the sign-extend/clamp helper functions.
REQ-031 Per-axis logic (delta extract, shift, clamp, accumulate, saturate, recentre) SHALL be sub-module paddle_axis, instantiated twice; the FSM and output multiplexing stay in paddle_emu.

Verification
REQ-032 Defaults: toggle strobe with X sign 0, byte 0x28 -> paddle_x = 10 one cycle later, upd = 1 for one cycle, src_mouse = 1.
REQ-033 14 further such packets -> paddle_x saturates at 127 with no wrap; then X sign 1, byte 0xF0 -> paddle_x = 119.
REQ-034 DEADZONE = 4, auto mode, mouse active: joya X = 3 -> stays SRC_MOUSE; joya X = 5 -> src_mouse = 0, paddle_x = 5, accumulators 0; next mouse packet restarts from 0.
REQ-035 Strobe toggle and joya X = 20 in the same cycle -> SRC_ANALOG, paddle_x = 20; mode 2 with the same stimulus -> SRC_MOUSE, paddle_x = clamped delta.
REQ-036 W = 10: joya X = -128 -> paddle_x = -512.
REQ-037 Reset asserted with paddle_x = 50 and strobe toggled during reset -> all outputs 0 and no upd pulse after release.
REQ-038 recentre coincident with X delta +6 (byte 0x0C) -> paddle_x = 6.

Source files
------------

// File: rtl/paddle_emu_pkg.sv
// Shared types, mode encodings and arithmetic helpers for the paddle emulator.
package paddle_emu_pkg;

   typedef enum logic {
      SRC_ANALOG = 1'b0,
      SRC_MOUSE  = 1'b1
   } src_t;

   localparam logic [1:0] MODE_AUTO   = 2'd0;
   localparam logic [1:0] MODE_ANALOG = 2'd1;
   localparam logic [1:0] MODE_MOUSE  = 2'd2;

   function automatic int sext8(input logic [7:0] v);
      return int'($signed(v));
   endfunction

   // Mouse deltas arrive as sign bit plus a two's-complement low byte.
   function automatic int sext9(input logic s, input logic [7:0] m);
      return int'($signed({s, m}));
   endfunction

   function automatic int clamp(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   function automatic int abs_int(input int v);
      return (v < 0) ? -v : v;
   endfunction

endpackage

// File: rtl/paddle_emu_if.sv
// Input/output bundle of the paddle emulator; the driver uses master, the emulator slave.
interface paddle_emu_if #(
   parameter int W = 8
);
   logic [24:0]         ps2_mouse;
   logic [15:0]         joya;
   logic [1:0]          mode;
   logic                recentre;
   logic signed [W-1:0] paddle_x;
   logic signed [W-1:0] paddle_y;
   logic [2:0]          btn;
   logic                src_mouse;
   logic                upd;

   modport master (
      output ps2_mouse, joya, mode, recentre,
      input  paddle_x, paddle_y, btn, src_mouse, upd
   );

   modport slave (
      input  ps2_mouse, joya, mode, recentre,
      output paddle_x, paddle_y, btn, src_mouse, upd
   );
endinterface

// File: rtl/paddle_axis.sv
// One mouse axis: scale and clamp the packet delta, then accumulate with saturation.
module paddle_axis
   import paddle_emu_pkg::*;
#(
   parameter int W        = 8,
   parameter int MAX_STEP = 10,
   parameter int SHIFT    = 1
) (
   input  logic                clk_sys,
   input  logic                reset,
   input  logic                sign_bit,
   input  logic [7:0]          mag_byte,
   input  logic                step_en,
   input  logic                clear,
   input  logic                recentre,
   output logic signed [W-1:0] acc_next
);

   logic signed [W-1:0] acc_reg;
   int delta;
   int base;
   int sum;

   // Sums are formed in 32 bits so saturation never sees a wrapped value.
   always_comb begin
      delta    = clamp(sext9(sign_bit, mag_byte) >>> SHIFT, -MAX_STEP, MAX_STEP);
      base     = recentre ? 0 : int'(acc_reg);
      sum      = clamp(base + delta, -(2 ** (W - 1)), (2 ** (W - 1)) - 1);
      acc_next = acc_reg;
      if (clear) begin
         acc_next = '0;
      end else if (step_en) begin
         acc_next = W'(sum);
      end else if (recentre) begin
         acc_next = '0;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         acc_reg <= '0;
      end else begin
         acc_reg <= acc_next;
      end
   end

endmodule

// File: rtl/paddle_emu.sv
// Paddle emulator: picks analog stick or PS/2 mouse as the paddle source and
// registers signed paddle positions with a change pulse.
module paddle_emu
   import paddle_emu_pkg::*;
#(
   parameter int W        = 8,
   parameter int MAX_STEP = 10,
   parameter int SHIFT    = 1,
   parameter int DEADZONE = 0
) (
   input logic         clk_sys,
   input logic         reset,
   paddle_emu_if.slave bus
);

   src_t                state_reg, state_next;
   logic                strobe_reg;
   logic                mouse_evt, analog_evt, step_en, clear_acc;
   int                  jx, jy;
   logic [1:0]          axis_sign;
   logic [7:0]          axis_mag [2];
   logic signed [W-1:0] axis_acc [2];
   logic signed [W-1:0] px_next, py_next, px_reg, py_reg;
   logic [2:0]          btn_next, btn_reg;
   logic                upd_reg;
   logic                unused_bits;

   assign unused_bits = ^{bus.ps2_mouse[7:6], bus.ps2_mouse[3]};

   assign mouse_evt  = bus.ps2_mouse[24] ^ strobe_reg;
   assign jx         = sext8(bus.joya[7:0]);
   assign jy         = sext8(bus.joya[15:8]);
   assign analog_evt = (abs_int(jx) > DEADZONE) || (abs_int(jy) > DEADZONE);

   always_comb begin
      state_next = state_reg;
      case (bus.mode)
         MODE_ANALOG: state_next = SRC_ANALOG;
         MODE_MOUSE:  state_next = SRC_MOUSE;
         default: begin
            if (analog_evt) begin
               state_next = SRC_ANALOG;
            end else if (mouse_evt) begin
               state_next = SRC_MOUSE;
            end
         end
      endcase
   end

   // Accumulators only live while the mouse is the source.
   assign step_en   = mouse_evt && (state_next == SRC_MOUSE);
   assign clear_acc = (state_next == SRC_ANALOG);

   assign axis_sign   = {bus.ps2_mouse[5], bus.ps2_mouse[4]};
   assign axis_mag[0] = bus.ps2_mouse[15:8];
   assign axis_mag[1] = bus.ps2_mouse[23:16];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_axis
         paddle_axis #(
            .W        (W),
            .MAX_STEP (MAX_STEP),
            .SHIFT    (SHIFT)
         ) u_axis (
            .clk_sys  (clk_sys),
            .reset    (reset),
            .sign_bit (axis_sign[gi]),
            .mag_byte (axis_mag[gi]),
            .step_en  (step_en),
            .clear    (clear_acc),
            .recentre (bus.recentre),
            .acc_next (axis_acc[gi])
         );
      end
   endgenerate

   always_comb begin
      px_next  = W'(jx <<< (W - 8));
      py_next  = W'(jy <<< (W - 8));
      btn_next = '0;
      if (state_next == SRC_MOUSE) begin
         px_next  = axis_acc[0];
         py_next  = axis_acc[1];
         btn_next = step_en ? bus.ps2_mouse[2:0] : btn_reg;
      end
   end

   // The strobe history follows the input even in reset so release sees no stale toggle.
   always_ff @(posedge clk_sys) begin
      strobe_reg <= bus.ps2_mouse[24];
      if (reset) begin
         state_reg <= SRC_ANALOG;
         px_reg    <= '0;
         py_reg    <= '0;
         btn_reg   <= '0;
         upd_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         px_reg    <= px_next;
         py_reg    <= py_next;
         btn_reg   <= btn_next;
         upd_reg   <= (px_next != px_reg) || (py_next != py_reg);
      end
   end

   assign bus.paddle_x  = px_reg;
   assign bus.paddle_y  = py_reg;
   assign bus.btn       = btn_reg;
   assign bus.src_mouse = (state_reg == SRC_MOUSE);
   assign bus.upd       = upd_reg;

endmodule

// File: tb/tb_paddle_emu.sv
// Bench for paddle_emu: two instances (W=8/DEADZONE=4 and W=10/DEADZONE=0) share
// one stimulus stream and are compared against a behavioural model.
module tb_paddle_emu;

   localparam int TB_SHIFT = 1;
   localparam int TB_MAX   = 10;

   logic        clk_sys = 1'b0;
   logic        reset_v = 1'b1;
   logic [24:0] ps2_v   = '0;
   logic [15:0] joya_v  = '0;
   logic [1:0]  mode_v  = 2'd0;
   logic        recentre_v = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_sys = ~clk_sys;

   paddle_emu_if #(.W(8))  if0 ();
   paddle_emu_if #(.W(10)) if1 ();

   assign if0.ps2_mouse = ps2_v;
   assign if0.joya      = joya_v;
   assign if0.mode      = mode_v;
   assign if0.recentre  = recentre_v;
   assign if1.ps2_mouse = ps2_v;
   assign if1.joya      = joya_v;
   assign if1.mode      = mode_v;
   assign if1.recentre  = recentre_v;

   paddle_emu #(.W(8), .MAX_STEP(10), .SHIFT(1), .DEADZONE(4)) dut0 (
      .clk_sys (clk_sys),
      .reset   (reset_v),
      .bus     (if0)
   );

   paddle_emu #(.W(10), .MAX_STEP(10), .SHIFT(1), .DEADZONE(0)) dut1 (
      .clk_sys (clk_sys),
      .reset   (reset_v),
      .bus     (if1)
   );

   int         obs_px [2];
   int         obs_py [2];
   logic [2:0] obs_btn [2];
   logic       obs_src [2];
   logic       obs_upd [2];

   assign obs_px[0]  = int'(if0.paddle_x);
   assign obs_py[0]  = int'(if0.paddle_y);
   assign obs_btn[0] = if0.btn;
   assign obs_src[0] = if0.src_mouse;
   assign obs_upd[0] = if0.upd;
   assign obs_px[1]  = int'(if1.paddle_x);
   assign obs_py[1]  = int'(if1.paddle_y);
   assign obs_btn[1] = if1.btn;
   assign obs_src[1] = if1.src_mouse;
   assign obs_upd[1] = if1.upd;

   // Behavioural model state, one slot per instance.
   int         wd [2] = '{8, 10};
   int         dz [2] = '{4, 0};
   bit         m_mouse [2];
   int         m_ax [2];
   int         m_ay [2];
   logic [2:0] m_btn [2];
   int         m_px [2];
   int         m_py [2];
   logic       m_upd [2];
   logic       m_prev = 1'b0;

   function automatic int step_of(input logic s, input logic [7:0] m);
      int v;
      int q;
      v = s ? int'(m) - 256 : int'(m);
      q = v / (2 ** TB_SHIFT);
      if (v < 0 && q * (2 ** TB_SHIFT) != v) q = q - 1;
      if (q > TB_MAX) q = TB_MAX;
      if (q < -TB_MAX) q = -TB_MAX;
      return q;
   endfunction

   function automatic int sat_w(input int v, input int w);
      int hi;
      hi = (2 ** (w - 1)) - 1;
      if (v > hi) return hi;
      if (v < -hi - 1) return -hi - 1;
      return v;
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic model_step();
      bit mev;
      bit aev;
      bit nm;
      int jx;
      int jy;
      int npx;
      int npy;
      mev = (ps2_v[24] != m_prev);
      jx  = int'($signed(joya_v[7:0]));
      jy  = int'($signed(joya_v[15:8]));
      for (int d = 0; d < 2; d++) begin
         if (reset_v) begin
            m_mouse[d] = 1'b0;
            m_ax[d] = 0;
            m_ay[d] = 0;
            m_btn[d] = 3'd0;
            m_px[d] = 0;
            m_py[d] = 0;
            m_upd[d] = 1'b0;
         end else begin
            aev = (iabs(jx) > dz[d]) || (iabs(jy) > dz[d]);
            if (mode_v == 2'd1) nm = 1'b0;
            else if (mode_v == 2'd2) nm = 1'b1;
            else if (aev) nm = 1'b0;
            else if (mev) nm = 1'b1;
            else nm = m_mouse[d];
            m_mouse[d] = nm;
            if (!nm) begin
               m_ax[d] = 0;
               m_ay[d] = 0;
               m_btn[d] = 3'd0;
               npx = jx * (2 ** (wd[d] - 8));
               npy = jy * (2 ** (wd[d] - 8));
            end else begin
               if (recentre_v) begin
                  m_ax[d] = 0;
                  m_ay[d] = 0;
               end
               if (mev) begin
                  m_ax[d] = sat_w(m_ax[d] + step_of(ps2_v[4], ps2_v[15:8]), wd[d]);
                  m_ay[d] = sat_w(m_ay[d] + step_of(ps2_v[5], ps2_v[23:16]), wd[d]);
                  m_btn[d] = ps2_v[2:0];
               end
               npx = m_ax[d];
               npy = m_ay[d];
            end
            m_upd[d] = (npx != m_px[d]) || (npy != m_py[d]);
            m_px[d] = npx;
            m_py[d] = npy;
         end
      end
      m_prev = ps2_v[24];
   endtask

   task automatic tick();
      @(posedge clk_sys);
      model_step();
      #1;
   endtask

   task automatic send_pkt(input logic xs, input logic [7:0] xm, input logic ys,
                           input logic [7:0] ym, input logic [2:0] b);
      ps2_v = {~ps2_v[24], ym, xm, 2'b00, ys, xs, 1'b0, b};
      tick();
      $display("pkt x=%0d/%02h y=%0d/%02h b=%0d -> px0=%0d px1=%0d src0=%0d upd0=%0d",
               xs, xm, ys, ym, b, obs_px[0], obs_px[1], obs_src[0], obs_upd[0]);
   endtask

   task automatic test_reset();
      reset_v = 1'b1;
      repeat (3) tick();
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (obs_px[d] !== 0 || obs_py[d] !== 0) begin
            n_fail++;
            $display("FAIL reset_pos dut%0d: got %0d,%0d required 0,0", d, obs_px[d], obs_py[d]);
         end
         n_checks++;
         if (obs_btn[d] !== 3'd0 || obs_src[d] !== 1'b0 || obs_upd[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags dut%0d: btn=%0d src=%0d upd=%0d required 0", d,
                     obs_btn[d], obs_src[d], obs_upd[d]);
         end
      end
      reset_v = 1'b0;
      tick();
      n_checks++;
      if (obs_upd[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_upd: got %0d required 0", obs_upd[0]);
      end
   endtask

   task automatic test_mouse_accumulate();
      send_pkt(1'b0, 8'h28, 1'b0, 8'h00, 3'b101);
      n_checks++;
      if (obs_px[0] !== 10 || obs_src[0] !== 1'b1 || obs_upd[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL first_step: px=%0d src=%0d upd=%0d required 10,1,1",
                  obs_px[0], obs_src[0], obs_upd[0]);
      end
      n_checks++;
      if (obs_btn[0] !== 3'b101) begin
         n_fail++;
         $display("FAIL first_btn: got %0d required 5", obs_btn[0]);
      end
      tick();
      n_checks++;
      if (obs_upd[0] !== 1'b0 || obs_px[0] !== 10) begin
         n_fail++;
         $display("FAIL idle_after_step: upd=%0d px=%0d required 0,10", obs_upd[0], obs_px[0]);
      end
      for (int i = 0; i < 14; i++) send_pkt(1'b0, 8'h28, 1'b0, 8'h00, 3'b000);
      n_checks++;
      if (obs_px[0] !== 127) begin
         n_fail++;
         $display("FAIL saturate_w8: got %0d required 127", obs_px[0]);
      end
      n_checks++;
      if (obs_px[1] !== 150) begin
         n_fail++;
         $display("FAIL accumulate_w10: got %0d required 150", obs_px[1]);
      end
      send_pkt(1'b1, 8'hF0, 1'b0, 8'h00, 3'b000);
      n_checks++;
      if (obs_px[0] !== 119 || obs_px[1] !== 142) begin
         n_fail++;
         $display("FAIL negative_step: got %0d,%0d required 119,142", obs_px[0], obs_px[1]);
      end
   endtask

   task automatic test_deadzone();
      joya_v = 16'h0003;
      tick();
      n_checks++;
      if (obs_src[0] !== 1'b1 || obs_px[0] !== 119) begin
         n_fail++;
         $display("FAIL inside_deadzone: src=%0d px=%0d required 1,119", obs_src[0], obs_px[0]);
      end
      n_checks++;
      if (obs_src[1] !== 1'b0 || obs_px[1] !== 12) begin
         n_fail++;
         $display("FAIL no_deadzone_w10: src=%0d px=%0d required 0,12", obs_src[1], obs_px[1]);
      end
      joya_v = 16'h0005;
      tick();
      n_checks++;
      if (obs_src[0] !== 1'b0 || obs_px[0] !== 5) begin
         n_fail++;
         $display("FAIL outside_deadzone: src=%0d px=%0d required 0,5", obs_src[0], obs_px[0]);
      end
      joya_v = 16'h0000;
      tick();
      send_pkt(1'b0, 8'h28, 1'b0, 8'h00, 3'b000);
      n_checks++;
      if (obs_px[0] !== 10 || obs_src[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_from_zero: px=%0d src=%0d required 10,1", obs_px[0], obs_src[0]);
      end
   endtask

   task automatic test_same_cycle();
      joya_v = 16'h0014;
      send_pkt(1'b0, 8'h28, 1'b0, 8'h00, 3'b000);
      n_checks++;
      if (obs_src[0] !== 1'b0 || obs_px[0] !== 20 || obs_px[1] !== 80) begin
         n_fail++;
         $display("FAIL analog_wins: src=%0d px=%0d,%0d required 0,20,80",
                  obs_src[0], obs_px[0], obs_px[1]);
      end
      mode_v = 2'd2;
      send_pkt(1'b0, 8'h28, 1'b0, 8'h00, 3'b000);
      n_checks++;
      if (obs_src[0] !== 1'b1 || obs_px[0] !== 10 || obs_px[1] !== 10) begin
         n_fail++;
         $display("FAIL mouse_only: src=%0d px=%0d,%0d required 1,10,10",
                  obs_src[0], obs_px[0], obs_px[1]);
      end
      mode_v = 2'd0;
      joya_v = 16'h0000;
      tick();
   endtask

   task automatic test_w10_extreme();
      joya_v = 16'h0080;
      tick();
      n_checks++;
      if (obs_px[1] !== -512 || obs_px[0] !== -128) begin
         n_fail++;
         $display("FAIL neg_full_scale: got %0d,%0d required -512,-128", obs_px[1], obs_px[0]);
      end
      joya_v = 16'h0000;
      tick();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) send_pkt(1'b0, 8'h28, 1'b0, 8'h00, 3'b010);
      n_checks++;
      if (obs_px[0] !== 50) begin
         n_fail++;
         $display("FAIL pre_reset_px: got %0d required 50", obs_px[0]);
      end
      reset_v = 1'b1;
      ps2_v[24] = ~ps2_v[24];
      repeat (2) tick();
      reset_v = 1'b0;
      tick();
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (obs_px[d] !== 0 || obs_upd[d] !== 1'b0 || obs_src[d] !== 1'b0 || obs_btn[d] !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_reset dut%0d: px=%0d upd=%0d src=%0d btn=%0d required 0", d,
                     obs_px[d], obs_upd[d], obs_src[d], obs_btn[d]);
         end
      end
   endtask

   task automatic test_recentre();
      for (int i = 0; i < 3; i++) send_pkt(1'b0, 8'h28, 1'b0, 8'h00, 3'b000);
      recentre_v = 1'b1;
      send_pkt(1'b0, 8'h0C, 1'b0, 8'h00, 3'b011);
      recentre_v = 1'b0;
      n_checks++;
      if (obs_px[0] !== 6 || obs_px[1] !== 6) begin
         n_fail++;
         $display("FAIL recentre_step: got %0d,%0d required 6,6", obs_px[0], obs_px[1]);
      end
      n_checks++;
      if (obs_btn[0] !== 3'b011) begin
         n_fail++;
         $display("FAIL recentre_btn: got %0d required 3", obs_btn[0]);
      end
   endtask

   task automatic test_random();
      logic [7:0] jx;
      logic [7:0] jy;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 15) == 0) mode_v = 2'($urandom_range(0, 3));
         reset_v    = ($urandom_range(0, 63) == 0);
         recentre_v = ($urandom_range(0, 15) == 0);
         ps2_v = {ps2_v[24] ^ 1'($urandom_range(0, 1)), 24'($urandom)};
         if ($urandom_range(0, 3) == 0) begin
            jx = 8'($urandom_range(0, 255));
            jy = 8'($urandom_range(0, 255));
         end else begin
            jx = 8'(250 + $urandom_range(0, 12));
            jy = 8'(250 + $urandom_range(0, 12));
         end
         joya_v = {jy, jx};
         tick();
         $display("rand %0d mode=%0d rst=%0d rc=%0d ps2=%07h joya=%04h -> px=%0d/%0d py=%0d/%0d src=%0d/%0d",
                  c, mode_v, reset_v, recentre_v, ps2_v, joya_v, obs_px[0], obs_px[1],
                  obs_py[0], obs_py[1], obs_src[0], obs_src[1]);
         for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (obs_px[d] !== m_px[d]) begin
               n_fail++;
               $display("FAIL rand_px dut%0d cyc%0d: got %0d required %0d", d, c, obs_px[d], m_px[d]);
            end
            n_checks++;
            if (obs_py[d] !== m_py[d]) begin
               n_fail++;
               $display("FAIL rand_py dut%0d cyc%0d: got %0d required %0d", d, c, obs_py[d], m_py[d]);
            end
            n_checks++;
            if (obs_btn[d] !== m_btn[d]) begin
               n_fail++;
               $display("FAIL rand_btn dut%0d cyc%0d: got %0d required %0d", d, c, obs_btn[d], m_btn[d]);
            end
            n_checks++;
            if (obs_src[d] !== m_mouse[d]) begin
               n_fail++;
               $display("FAIL rand_src dut%0d cyc%0d: got %0d required %0d", d, c, obs_src[d], m_mouse[d]);
            end
            n_checks++;
            if (obs_upd[d] !== m_upd[d]) begin
               n_fail++;
               $display("FAIL rand_upd dut%0d cyc%0d: got %0d required %0d", d, c, obs_upd[d], m_upd[d]);
            end
         end
      end
      reset_v    = 1'b0;
      recentre_v = 1'b0;
   endtask

   initial begin
      test_reset();
      test_mouse_accumulate();
      test_deadzone();
      test_same_cycle();
      test_w10_extreme();
      test_reset_mid();
      test_recentre();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
